// File: rtl/data_mem_pipe.sv
// Byte-addressable 32-bit data memory with a READ_LATENCY-stage load pipeline.
// Latency: a load accepted in cycle N responds in cycle N+READ_LATENCY; a store commits at its accept edge.
// Backpressure: resp_valid_o && !resp_ready_i freezes every stage and drops req_ready_o.
//
// Ports: clk_i/rst_i (async active-high); req_* request channel (valid/ready);
//        resp_* load response channel (valid/ready); store_error_o one-cycle drop pulse.
// Optional: define DATA_MEM_PIPE_TRACE_EN to print every committed store.
module data_mem_pipe #(
    parameter int unsigned DEPTH_WORDS  = 4096,
    parameter int unsigned READ_LATENCY = 1,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [31:0] req_addr_i,
    input  logic [1:0]  req_width_i,
    input  logic        req_sign_i,
    input  logic [31:0] req_wdata_i,
    input  logic [31:0] req_pc_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_data_o,
    output logic        resp_error_o,
    output logic        store_error_o
);

    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0]             mem_q [DEPTH_WORDS];
    logic [READ_LATENCY-1:0] vld_q;
    logic [READ_LATENCY-1:0] err_q;
    logic [31:0]             dat_q [READ_LATENCY];
    logic                    store_err_q;

    // The whole pipeline, including store commit, moves only when the output
    // stage is not blocked by the consumer.
    logic advance;
    logic accept;
    assign advance     = !(vld_q[READ_LATENCY-1] && !resp_ready_i);
    assign req_ready_o = advance;
    assign accept      = req_valid_i && advance;

    // Address decode. An address below BASE_ADDR wraps to a huge offset, but it
    // is also rejected explicitly so the intent is obvious.
    logic [31:0]   offset;
    logic [AW-1:0] idx;
    logic          out_of_range;
    logic          misaligned;
    logic          fault;
    assign offset       = req_addr_i - BASE_ADDR;
    assign idx          = offset[AW+1:2];
    assign out_of_range = (req_addr_i < BASE_ADDR) || ({2'b00, offset[31:2]} >= DEPTH_WORDS);
    assign misaligned   = ((req_width_i == 2'b01) && req_addr_i[0])
                       || (req_width_i[1] && (req_addr_i[1:0] != 2'b00));
    assign fault        = out_of_range || misaligned;

    logic [31:0] rd_word;
    logic [4:0]  byte_sh;
    logic [4:0]  half_sh;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    assign rd_word   = mem_q[idx];
    assign byte_sh   = {req_addr_i[1:0], 3'b000};
    assign half_sh   = {req_addr_i[1], 4'b0000};
    assign byte_lane = rd_word[byte_sh +: 8];
    assign half_lane = rd_word[half_sh +: 16];

    // Load result as it enters stage 0; faulting loads carry zero data.
    logic [31:0] load_dat_d;
    always_comb begin
        load_dat_d = 32'h0;
        if (!fault) begin
            case (req_width_i)
                2'b00:   load_dat_d = {{24{req_sign_i & byte_lane[7]}}, byte_lane};
                2'b01:   load_dat_d = {{16{req_sign_i & half_lane[15]}}, half_lane};
                default: load_dat_d = rd_word;
            endcase
        end
    end

    // Store merge: read-modify-write of the addressed word, little-endian lanes.
    logic [31:0] wr_mask;
    logic [31:0] wr_shift;
    logic [31:0] wr_word_d;
    always_comb begin
        wr_mask  = 32'hFFFF_FFFF;
        wr_shift = req_wdata_i;
        case (req_width_i)
            2'b00: begin
                wr_mask  = 32'h0000_00FF << byte_sh;
                wr_shift = {24'h0, req_wdata_i[7:0]} << byte_sh;
            end
            2'b01: begin
                wr_mask  = 32'h0000_FFFF << half_sh;
                wr_shift = {16'h0, req_wdata_i[15:0]} << half_sh;
            end
            default: ;
        endcase
        wr_word_d = (rd_word & ~wr_mask) | (wr_shift & wr_mask);
    end

    logic store_commit;
    logic load_accept;
    assign store_commit = accept && req_write_i && !fault;
    assign load_accept  = accept && !req_write_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH_WORDS); i++) begin
                mem_q[i] <= 32'h0;
            end
        end else if (store_commit) begin
            mem_q[idx] <= wr_word_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q       <= '0;
            err_q       <= '0;
            store_err_q <= 1'b0;
            for (int i = 0; i < int'(READ_LATENCY); i++) begin
                dat_q[i] <= 32'h0;
            end
        end else begin
            store_err_q <= accept && req_write_i && fault;
            if (advance) begin
                // Bubbles enter as all-zero stages so idle outputs stay quiet.
                vld_q[0] <= load_accept;
                err_q[0] <= load_accept && fault;
                dat_q[0] <= load_accept ? load_dat_d : 32'h0;
                for (int i = 1; i < int'(READ_LATENCY); i++) begin
                    vld_q[i] <= vld_q[i-1];
                    err_q[i] <= err_q[i-1];
                    dat_q[i] <= dat_q[i-1];
                end
            end
        end
    end

    assign resp_valid_o  = vld_q[READ_LATENCY-1];
    assign resp_data_o   = dat_q[READ_LATENCY-1];
    assign resp_error_o  = err_q[READ_LATENCY-1];
    assign store_error_o = store_err_q;

    logic unused_bits;
`ifdef DATA_MEM_PIPE_TRACE_EN
    // Reported PC is req_pc_i-8 to line up with the issuing instruction.
    always_ff @(posedge clk_i) begin
        if (!rst_i && store_commit) begin
            $display("@%h: *%h <= %h", req_pc_i - 32'd8, {req_addr_i[31:2], 2'b00}, wr_word_d);
        end
    end
    assign unused_bits = ^offset[1:0];
`else
    assign unused_bits = ^{req_pc_i, offset[1:0]};
`endif

endmodule

// File: tb/tb_data_mem_pipe.sv
module tb_data_mem_pipe;

    localparam int          DEPTH = 64;
    localparam int          LAT   = 2;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int          MEMB  = DEPTH * 4;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_write_i = 1'b0;
    logic [31:0] req_addr_i = 32'h0;
    logic [1:0]  req_width_i = 2'b00;
    logic        req_sign_i = 1'b0;
    logic [31:0] req_wdata_i = 32'h0;
    logic [31:0] req_pc_i = 32'h0;
    logic        resp_valid_o;
    logic        resp_ready_i = 1'b1;
    logic [31:0] resp_data_o;
    logic        resp_error_o;
    logic        store_error_o;

    data_mem_pipe #(
        .DEPTH_WORDS (DEPTH),
        .READ_LATENCY(LAT),
        .BASE_ADDR   (BASE)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_write_i  (req_write_i),
        .req_addr_i   (req_addr_i),
        .req_width_i  (req_width_i),
        .req_sign_i   (req_sign_i),
        .req_wdata_i  (req_wdata_i),
        .req_pc_i     (req_pc_i),
        .resp_valid_o (resp_valid_o),
        .resp_ready_i (resp_ready_i),
        .resp_data_o  (resp_data_o),
        .resp_error_o (resp_error_o),
        .store_error_o(store_error_o)
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;

    // Reference model: byte-addressed memory plus a queue of pending responses,
    // each carrying how many more pipeline advances it needs before it shows.
    typedef struct {
        logic [31:0] d;
        logic        e;
        int          cnt;
    } resp_t;

    logic [7:0] mm [MEMB];
    resp_t      pq [$];
    logic       exp_serr     = 1'b0;
    int         stall_budget = 0;
    bit         rand_rr      = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit mfault(input logic [31:0] a, input logic [1:0] w);
        logic [31:0] off;
        bit mis;
        off = a - BASE;
        mis = ((w == 2'b01) && a[0]) || (w[1] && (a[1:0] != 2'b00));
        return mis || (off >= 32'(MEMB));
    endfunction

    function automatic logic [31:0] mload(input logic [31:0] a, input logic [1:0] w, input logic s);
        logic [31:0] off;
        logic [15:0] h;
        off = a - BASE;
        if (w == 2'b00) return s ? 32'($signed(mm[off])) : {24'h0, mm[off]};
        h = {mm[off+1], mm[off]};
        if (w == 2'b01) return s ? 32'($signed(h)) : {16'h0, h};
        return {mm[off+3], mm[off+2], h};
    endfunction

    task automatic mstore(input logic [31:0] a, input logic [1:0] w, input logic [31:0] d);
        logic [31:0] off;
        off = a - BASE;
        mm[off] = d[7:0];
        if (w != 2'b00) mm[off+1] = d[15:8];
        if (w[1]) begin
            mm[off+2] = d[23:16];
            mm[off+3] = d[31:24];
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < MEMB; i++) mm[i] = 8'h00;
        pq.delete();
        exp_serr = 1'b0;
    endtask

    // One clock cycle, entered and left at a falling edge with inputs already set.
    task automatic tick(output bit acc);
        bit    ev;
        bit    rr;
        bit    stall;
        bit    new_serr;
        resp_t r;
        ev = (pq.size() > 0) && (pq[0].cnt == 0);
        if (stall_budget > 0 && ev) begin
            rr = 1'b0;
            stall_budget--;
        end else if (rand_rr) begin
            rr = ($urandom_range(0, 3) != 0);
        end else begin
            rr = 1'b1;
        end
        resp_ready_i = rr;
        stall = ev && !rr;
        #1;
        chk("resp_valid", 32'(resp_valid_o), 32'(ev));
        chk("req_ready", 32'(req_ready_o), 32'(!stall));
        chk("store_error", 32'(store_error_o), 32'(exp_serr));
        if (ev) begin
            chk("resp_data", resp_data_o, pq[0].d);
            chk("resp_error", 32'(resp_error_o), 32'(pq[0].e));
        end
        acc = req_valid_i && !stall;
        new_serr = 1'b0;
        if (ev && rr) void'(pq.pop_front());
        if (!stall) begin
            for (int i = 0; i < pq.size(); i++) begin
                r = pq[i];
                if (r.cnt > 0) r.cnt--;
                pq[i] = r;
            end
        end
        if (acc) begin
            if (req_write_i) begin
                if (mfault(req_addr_i, req_width_i)) new_serr = 1'b1;
                else mstore(req_addr_i, req_width_i, req_wdata_i);
            end else begin
                r.e   = mfault(req_addr_i, req_width_i);
                r.d   = r.e ? 32'h0 : mload(req_addr_i, req_width_i, req_sign_i);
                r.cnt = LAT - 1;
                pq.push_back(r);
            end
        end
        exp_serr = new_serr;
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic do_req(input bit w, input logic [31:0] a, input logic [1:0] wd,
                          input bit s, input logic [31:0] d);
        bit acc;
        int n;
        req_valid_i = 1'b1;
        req_write_i = w;
        req_addr_i  = a;
        req_width_i = wd;
        req_sign_i  = s;
        req_wdata_i = d;
        req_pc_i    = req_pc_i + 32'd4;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 20) begin
            tick(acc);
            n++;
        end
        chk("accept_within_bound", 32'(acc), 32'd1);
        req_valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        bit acc;
        req_valid_i = 1'b0;
        for (int i = 0; i < n; i++) tick(acc);
    endtask

    initial begin
        bit acc;
        model_reset();

        // Reset state
        @(negedge clk_i);
        #1;
        chk("rst_resp_valid", 32'(resp_valid_o), 32'd0);
        chk("rst_resp_data", resp_data_o, 32'h0);
        chk("rst_resp_error", 32'(resp_error_o), 32'd0);
        chk("rst_store_error", 32'(store_error_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("rst_req_ready", 32'(req_ready_o), 32'd1);
        @(negedge clk_i);

        // Word store then word load, two-cycle latency checked by the model
        do_req(1, 32'h10, 2'b10, 0, 32'h1234_5678);
        do_req(0, 32'h10, 2'b10, 0, 32'h0);
        idle(4);

        // Byte store into word 0x20, signed/unsigned byte and full-word loads
        do_req(1, 32'h21, 2'b00, 0, 32'h0000_0080);
        do_req(0, 32'h21, 2'b00, 1, 32'h0);
        do_req(0, 32'h21, 2'b00, 0, 32'h0);
        do_req(0, 32'h20, 2'b10, 0, 32'h0);
        idle(4);

        // Misaligned and out-of-range traffic
        do_req(1, 32'h32, 2'b10, 0, 32'hAABB_CCDD);
        do_req(0, 32'h30, 2'b10, 0, 32'h0);
        do_req(0, 32'h31, 2'b01, 0, 32'h0);
        do_req(1, 32'(MEMB), 2'b00, 0, 32'h55);
        do_req(0, 32'(MEMB), 2'b00, 0, 32'h0);
        do_req(1, 32'(MEMB - 4), 2'b10, 0, 32'hCAFE_F00D);
        do_req(0, 32'(MEMB - 2), 2'b01, 1, 32'h0);
        idle(4);

        // Back-to-back loads with a three-cycle consumer stall
        do_req(1, 32'h0, 2'b10, 0, 32'h1111_1111);
        do_req(1, 32'h4, 2'b10, 0, 32'h2222_2222);
        do_req(1, 32'h8, 2'b10, 0, 32'h3333_3333);
        stall_budget = 3;
        do_req(0, 32'h0, 2'b10, 0, 32'h0);
        do_req(0, 32'h4, 2'b10, 0, 32'h0);
        do_req(0, 32'h8, 2'b10, 0, 32'h0);
        idle(6);

        // Store-to-load ordering: new data after a store, old data before it
        do_req(1, 32'h40, 2'b10, 0, 32'hDEAD_BEEF);
        do_req(0, 32'h40, 2'b10, 0, 32'h0);
        do_req(1, 32'h44, 2'b10, 0, 32'h0BAD_F00D);
        do_req(0, 32'h44, 2'b01, 0, 32'h0);
        do_req(1, 32'h44, 2'b01, 0, 32'h0000_7777);
        idle(4);

        // Reset with two loads in flight
        do_req(0, 32'h10, 2'b10, 0, 32'h0);
        do_req(0, 32'h40, 2'b10, 0, 32'h0);
        rst_i = 1'b1;
        #1;
        chk("midrst_resp_valid", 32'(resp_valid_o), 32'd0);
        chk("midrst_resp_data", resp_data_o, 32'h0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        model_reset();
        idle(6);
        do_req(0, 32'h10, 2'b10, 0, 32'h0);
        do_req(0, 32'h40, 2'b10, 0, 32'h0);
        idle(4);

        // Randomized traffic with random consumer backpressure
        rand_rr = 1'b1;
        for (int i = 0; i < 400; i++) begin
            req_valid_i = ($urandom_range(0, 9) < 7);
            req_write_i = ($urandom_range(0, 9) < 4);
            req_addr_i  = 32'($urandom_range(0, MEMB + 40));
            req_width_i = 2'($urandom_range(0, 3));
            req_sign_i  = 1'($urandom_range(0, 1));
            req_wdata_i = $urandom;
            req_pc_i    = $urandom;
            tick(acc);
        end
        rand_rr = 1'b0;
        idle(8);
        chk("drain_empty", 32'(pq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
